// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage ahead of control_unit. Holds the PC and fetches 32-bit words
// from instruction memory over a variable-latency req/ready handshake. It
// latches each word into the instruction register (IR) and exposes its opcode
// to the decoder. When the datapath reports completion, it advances the PC
// using the jump/branch controls and the ALU zero flag, and counts retired
// instructions.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   imem_req     out  fetch request (FETCH state only)
//   imem_addr    out  fetch byte address (= pc)
//   imem_rdata   in   instruction word, valid with imem_ready
//   imem_ready   in   memory response strobe
//   instr        out  instruction register
//   opcode       out  instr[31:26]
//   instr_valid  out  IR holds the instruction under execution (ISSUE state)
//   pc           out  address of the current instruction
//   pc_plus4     out  pc + 4 (link value for JAL)
//   branch       in   decoder branch control
//   jump         in   decoder jump control
//   alu_zero     in   ALU zero flag for the current instruction
//   exec_done    in   datapath finished the current instruction
//   instr_count  out  retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [5:0]  BNE_OPCODE = 6'b100111
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        jump,
  input  logic        alu_zero,
  input  logic        exec_done,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] next_pc;

  // Next-PC selection: jump beats a taken branch, which beats sequential flow.
  // The BNE opcode flips the sense of the zero flag.
  function automatic logic [31:0] calc_next_pc(
    input logic [31:0] cur_pc,
    input logic [31:0] ir,
    input logic        br,
    input logic        jmp,
    input logic        zero
  );
    logic [31:0]        seq;
    logic signed [31:0] boff;
    logic               taken;
    seq   = cur_pc + 32'd4;
    boff  = {{14{ir[15]}}, ir[15:0], 2'b00};
    taken = br & (zero ^ (ir[31:26] == BNE_OPCODE));
    if (jmp)
      return {seq[31:28], ir[25:0], 2'b00};
    else if (taken)
      return seq + $unsigned(boff);
    else
      return seq;
  endfunction

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign opcode    = instr[31:26];
  assign next_pc   = calc_next_pc(pc, instr, branch, jump, alu_zero);

  // imem_req / instr_valid are registered alongside the state so they always
  // equal the decode of the state register, without a combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_count <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            state       <= ISSUE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (exec_done) begin
            pc          <= next_pc;
            instr_count <= instr_count + 32'd1;
            state       <= FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
